// File: rtl/bounded_coord_counter.sv
// Bounded up/down/load coordinate counter with wrap-or-saturate bounds and terminal-count flags.
// Optional step prescaler is built only when STEP_PRESCALE_EN is defined.
module bounded_coord_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned MAX_VAL = 8,
  parameter int unsigned RST_VAL = 0,
  parameter int unsigned DIV     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             UP,
  input  logic             DW,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             step,
  input  logic             wrap,
  output logic [WIDTH-1:0] Q,
  output logic             UTC,
  output logic             DTC,
  output logic             WRP
);

  localparam logic [WIDTH-1:0] MIN_Q = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic             count_en;
  logic [WIDTH-1:0] q_next;
  logic             wrp_next;

`ifdef STEP_PRESCALE_EN
  localparam bit          PRESCALE = 1'b1;
  localparam int unsigned PW       = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;

  // Strobe fires on the DIV-th step-high cycle; a load restarts the count.
  assign count_en = step && (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              pre_cnt <= '0;
    else if (LD || count_en) pre_cnt <= '0;
    else if (step)           pre_cnt <= pre_cnt + PW'(1);
  end
`else
  localparam bit PRESCALE = 1'b0;

  assign count_en = step;
`endif

  if (MIN_VAL >= MAX_VAL) begin : g_bad_range
    $error("bounded_coord_counter: MIN_VAL must be below MAX_VAL");
  end
  if ((MAX_VAL >> WIDTH) != 0) begin : g_bad_max
    $error("bounded_coord_counter: MAX_VAL does not fit in WIDTH bits");
  end
  if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_bad_rst
    $error("bounded_coord_counter: RST_VAL outside [MIN_VAL, MAX_VAL]");
  end
  if (PRESCALE && DIV < 2) begin : g_bad_div
    $error("bounded_coord_counter: DIV must be at least 2");
  end

  always_comb begin
    q_next   = Q;
    wrp_next = 1'b0;
    if (LD) begin
      // Comparisons written inclusively so a zero bound never forms a constant compare.
      if (D >= MAX_Q)      q_next = MAX_Q;
      else if (D <= MIN_Q) q_next = MIN_Q;
      else                 q_next = D;
    end else if (count_en && (UP ^ DW)) begin
      if (UP) begin
        if (Q == MAX_Q) begin
          if (wrap) begin
            q_next   = MIN_Q;
            wrp_next = 1'b1;
          end
        end else begin
          q_next = Q + WIDTH'(1);
        end
      end else begin
        if (Q == MIN_Q) begin
          if (wrap) begin
            q_next   = MAX_Q;
            wrp_next = 1'b1;
          end
        end else begin
          q_next = Q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Q   <= RST_Q;
      WRP <= 1'b0;
    end else begin
      Q   <= q_next;
      WRP <= wrp_next;
    end
  end

  assign UTC = (Q == MAX_Q);
  assign DTC = (Q == MIN_Q);

endmodule

// File: tb/tb_bounded_coord_counter.sv
// Directed and randomized bench for bounded_coord_counter against an integer reference model.
module tb_bounded_coord_counter;

  localparam int WIDTH   = 8;
  localparam int MIN_VAL = 0;
  localparam int MAX_VAL = 8;
  localparam int RST_VAL = 0;
  localparam int DIV     = 4;
  localparam int SPAN    = MAX_VAL - MIN_VAL + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             UP, DW, LD, step, wrap;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             UTC, DTC, WRP;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int mq;
  int mw;
  int mpre;

  bounded_coord_counter #(
    .WIDTH(WIDTH), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL), .RST_VAL(RST_VAL), .DIV(DIV)
  ) dut (
    .clk(clk), .reset(reset), .UP(UP), .DW(DW), .LD(LD), .D(D),
    .step(step), .wrap(wrap), .Q(Q), .UTC(UTC), .DTC(DTC), .WRP(WRP)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".Q"},   32'(Q),   32'(mq));
    chk({tag, ".UTC"}, 32'(UTC), 32'(mq == MAX_VAL));
    chk({tag, ".DTC"}, 32'(DTC), 32'(mq == MIN_VAL));
    chk({tag, ".WRP"}, 32'(WRP), 32'(mw));
  endtask

  // Drive one cycle of inputs, advance the model arithmetically, then compare after the edge.
  task automatic cyc(input string tag, input bit up, input bit dw, input bit ld,
                     input int d, input bit st, input bit wr);
    int  nq;
    int  nw;
    bit  strobe;
    UP = up; DW = dw; LD = ld; D = WIDTH'(d); step = st; wrap = wr;
    strobe = st;
`ifdef STEP_PRESCALE_EN
    strobe = 1'b0;
    if (ld) mpre = 0;
    else if (st) begin
      mpre++;
      if (mpre == DIV) begin
        strobe = 1'b1;
        mpre   = 0;
      end
    end
`endif
    nq = mq;
    nw = 0;
    if (ld) begin
      nq = (d > MAX_VAL) ? MAX_VAL : (d < MIN_VAL) ? MIN_VAL : d;
    end else if (strobe && (up != dw)) begin
      nq = mq + (up ? 1 : -1);
      if (nq > MAX_VAL) begin
        nq = wr ? MIN_VAL : MAX_VAL;
        nw = wr ? 1 : 0;
      end else if (nq < MIN_VAL) begin
        nq = wr ? MAX_VAL : MIN_VAL;
        nw = wr ? 1 : 0;
      end
    end
    @(posedge clk);
    #1;
    mq = nq;
    mw = nw;
    chk_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    UP = 1'b0; DW = 1'b0; LD = 1'b0; D = '0; step = 1'b0; wrap = 1'b0;
    mq = RST_VAL; mw = 0; mpre = 0;
    #1;
    chk_all("reset_state");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all("post_release");

    // Up count with wrap: climb to the top, then wrap to the bottom with a one-cycle pulse.
    for (int i = 0; i < SPAN - 1; i++) cyc("up_wrap", 1, 0, 0, 0, 1, 1);
    chk("utc_at_top", 32'(UTC), 32'd1);
    chk("q_at_top", 32'(Q), 32'(MAX_VAL));
    cyc("wrap_step", 1, 0, 0, 0, 1, 1);
    chk("wrp_pulse", 32'(WRP), 32'd1);
    chk("q_wrapped", 32'(Q), 32'(MIN_VAL));
    cyc("wrp_clear", 0, 0, 0, 0, 0, 1);
    chk("wrp_one_cycle", 32'(WRP), 32'd0);

    // Saturation at both ends
    cyc("sat_down", 0, 1, 0, 0, 1, 0);
    cyc("sat_down", 0, 1, 0, 0, 1, 0);
    chk("sat_low_q", 32'(Q), 32'(MIN_VAL));
    cyc("load_clamp", 0, 0, 1, 200, 0, 0);
    chk("clamp_high", 32'(Q), 32'(MAX_VAL));
    cyc("sat_up", 1, 0, 0, 0, 1, 0);
    cyc("sat_up", 1, 0, 0, 0, 1, 0);
    chk("sat_high_q", 32'(Q), 32'(MAX_VAL));
    chk("sat_high_wrp", 32'(WRP), 32'd0);

    // Wrap downward from the bottom
    cyc("load_low", 0, 0, 1, 0, 0, 1);
    cyc("down_wrap", 0, 1, 0, 0, 1, 1);
    chk("down_wrap_q", 32'(Q), 32'(MAX_VAL));

    // Load wins over a simultaneous count; then hold cases
    cyc("load_wins", 1, 0, 1, 3, 1, 1);
    chk("load_wins_q", 32'(Q), 32'd3);
`ifndef STEP_PRESCALE_EN
    cyc("up_to_4", 1, 0, 0, 0, 1, 1);
    chk("q_is_4", 32'(Q), 32'd4);
`endif
    cyc("hold_both", 1, 1, 0, 0, 1, 1);
    cyc("hold_nostep", 1, 0, 0, 0, 0, 1);

`ifdef STEP_PRESCALE_EN
    cyc("pre_load0", 0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 12; i++) cyc("prescale", 1, 0, 0, 0, 1, 1);
    chk("prescale_q", 32'(Q), 32'd3);
`endif

    // Asynchronous reset mid-count, checked before any clock edge
    cyc("load5", 0, 0, 1, 5, 0, 1);
    UP = 1'b1; step = 1'b1; wrap = 1'b1;
    #3;
    reset = 1'b0;
    #1;
    mq = RST_VAL; mw = 0; mpre = 0;
    chk_all("async_reset");
    chk("async_reset_q", 32'(Q), 32'd0);
    UP = 1'b0; step = 1'b0;
    #2;
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, 255)),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
